rx_bypass_ctrl: RTL and testbench

//  Rx-side sequencer for the PTPv2 datapath bypass mux (timestamp-engine output vs raw XGMII).

---
 rtl/rx_bypass_ctrl_if.sv | 31 +++
 rtl/rx_bypass_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rx_bypass_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_bypass_ctrl_if.sv
// ----------------------------------------------------------------------------
// rx_bypass_ctrl_if
//   Raw rx XGMII monitor bus and the SFD timestamp trigger path used by
//   rx_bypass_ctrl.
//   xge_rxd_i   64  raw rx XGMII data (monitored only)
//   xge_rxc_i    8  raw rx XGMII control, one bit per byte lane
//   rxts_trig_i  1  SFD trigger from rx_tse
//   rxts_trig_o  1  trigger after bypass gating
//   master: the side that drives the XGMII bus and the raw trigger
//   slave : rx_bypass_ctrl
// ----------------------------------------------------------------------------
interface rx_bypass_ctrl_if;
  logic [63:0] xge_rxd_i;
  logic [7:0]  xge_rxc_i;
  logic        rxts_trig_i;
  logic        rxts_trig_o;

  modport master (
    output xge_rxd_i,
    output xge_rxc_i,
    output rxts_trig_i,
    input  rxts_trig_o
  );

  modport slave (
    input  xge_rxd_i,
    input  xge_rxc_i,
    input  rxts_trig_i,
    output rxts_trig_o
  );
endinterface

// File: rtl/rx_bypass_ctrl.sv
// ----------------------------------------------------------------------------
// rx_bypass_ctrl
//   Rx-side sequencer for the PTPv2 bypass mux (rx_tse output vs raw XGMII).
//   An asynchronous bypass request is synchronised, then the mux select is
//   moved only once the line has been idle for TSE_LAT enabled cycles, so the
//   rx_tse pipeline has drained and no frame is cut. A drain that never finds
//   a gap is forced after 2^WAIT_W-1 enabled cycles and flagged in forced_o.
//
// Ports
//   rx_clk, rx_rst_n   clock, asynchronous active-low reset
//   rx_clk_en_i        clock enable; frame/idle/wait state advances only when 1
//   bypass_req_i       async level request: 1=bypass, 0=PTP path
//   forced_clr_i       synchronous clear of forced_o, wins over a new set
//   xgmii (slave)      raw XGMII monitor bus + SFD trigger in/out
//   sel_bypass_o       mux select: 1=raw XGMII, 0=rx_tse output
//   frame_active_o     a frame is in progress on the input
//   switch_done_o      one-cycle pulse in the first cycle of the new select
//   forced_o           sticky: a switch was forced by timeout
//   switch_cnt_o       completed switches, wraps
//   state_o            sequencer state (PTP=00 DRAIN_BYP=01 BYP=10 DRAIN_PTP=11)
//
// Event semantics: there is no backpressure. switch_done_o acts as a valid
// strobe that is high for exactly one rx_clk; sel_bypass_o, forced_o and
// switch_cnt_o already show the post-switch values in that cycle.
// ----------------------------------------------------------------------------
module rx_bypass_ctrl #(
  parameter int TSE_LAT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_W      = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic             rx_clk_en_i,
  input  logic             bypass_req_i,
  input  logic             forced_clr_i,
  rx_bypass_ctrl_if.slave  xgmii,
  output logic             sel_bypass_o,
  output logic             frame_active_o,
  output logic             switch_done_o,
  output logic             forced_o,
  output logic [15:0]      switch_cnt_o,
  output logic [1:0]       state_o
);

  localparam int IDLE_W = (TSE_LAT > 1) ? $clog2(TSE_LAT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TSE_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_PTP       = 2'b00,
    ST_DRAIN_BYP = 2'b01,
    ST_BYP       = 2'b10,
    ST_DRAIN_PTP = 2'b11
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
  logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                     sel_q;
  logic                     frame_q, frame_d;
  logic                     switch_done_q;
  logic                     forced_q;
  logic [15:0]              switch_cnt_q;

  logic req_s;
  logic start_w, term_w, idle_word;
  logic do_switch, do_force;

  // Request synchroniser: free-running, independent of the clock enable.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bypass_req_i};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Start is only legal in lane 0 or lane 4; terminate may sit in any lane.
  // A start has priority, so "FD in a low lane + FB in lane 4" keeps the
  // frame open. FE is never treated as an end of frame.
  always_comb begin
    start_w = (xgmii.xge_rxc_i[0] && (xgmii.xge_rxd_i[7:0]   == 8'hFB)) ||
              (xgmii.xge_rxc_i[4] && (xgmii.xge_rxd_i[39:32] == 8'hFB));
    term_w  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (xgmii.xge_rxc_i[k] && (xgmii.xge_rxd_i[8*k +: 8] == 8'hFD)) begin
        term_w = 1'b1;
      end
    end
    frame_d = start_w ? 1'b1 : (term_w ? 1'b0 : frame_q);
  end

  // Uses the registered frame state: the terminate word itself is not idle.
  assign idle_word = rx_clk_en_i & ~frame_q & ~start_w;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wait_cnt_d = wait_cnt_q;
    do_switch  = 1'b0;
    do_force   = 1'b0;
    case (state_q)
      ST_PTP: begin
        if (req_s) begin
          state_d    = ST_DRAIN_BYP;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
        end
      end
      ST_BYP: begin
        if (!req_s) begin
          state_d    = ST_DRAIN_PTP;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
        end
      end
      ST_DRAIN_BYP, ST_DRAIN_PTP: begin
        // sel_q still reflects the source state, so req_s == sel_q means
        // the request has been withdrawn.
        if (req_s == sel_q) begin
          state_d    = sel_q ? ST_BYP : ST_PTP;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
        end else if (rx_clk_en_i) begin
          if (wait_cnt_q == WAIT_MAX) begin
            do_switch = 1'b1;
            do_force  = 1'b1;
          end else if (idle_word && (idle_cnt_q == IDLE_LAST)) begin
            do_switch = 1'b1;
          end else begin
            // Cannot overflow: the maximum value forces a switch above.
            wait_cnt_d = wait_cnt_q + 1'b1;
            idle_cnt_d = idle_word ? idle_cnt_q + 1'b1 : '0;
          end
          if (do_switch) begin
            state_d    = sel_q ? ST_PTP : ST_BYP;
            idle_cnt_d = '0;
            wait_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_PTP;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q       <= ST_PTP;
      idle_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      sel_q         <= 1'b0;
      frame_q       <= 1'b0;
      switch_done_q <= 1'b0;
      forced_q      <= 1'b0;
      switch_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      switch_done_q <= do_switch;
      if (do_switch) begin
        sel_q        <= ~sel_q;
        switch_cnt_q <= switch_cnt_q + 16'd1;
      end
      if (forced_clr_i) begin
        forced_q <= 1'b0;
      end else if (do_force) begin
        forced_q <= 1'b1;
      end
      if (rx_clk_en_i) begin
        frame_q <= frame_d;
      end
    end
  end

  assign xgmii.rxts_trig_o = xgmii.rxts_trig_i & ~sel_q;
  assign sel_bypass_o      = sel_q;
  assign frame_active_o    = frame_q;
  assign switch_done_o     = switch_done_q;
  assign forced_o          = forced_q;
  assign switch_cnt_o      = switch_cnt_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_rx_bypass_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rx_bypass_ctrl
//   Directed scenarios followed by a randomized phase. A reference model
//   tracks the line and the switch rules at the word level; each predicted
//   switch pushes its expected outcome into exp_q, and a negedge monitor pops
//   it when the DUT raises switch_done_o. The monitor also compares every
//   visible output to the model on every cycle.
// ----------------------------------------------------------------------------
module tb_rx_bypass_ctrl;

  localparam int TSE_LAT     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int WAIT_W      = 6;
  localparam int WAIT_MAX    = (1 << WAIT_W) - 1;
  localparam logic [63:0] IDLE_D = {8{8'h07}};
  localparam int SB_W = 18;

  // ---------------- clock / reset ----------------
  logic        rx_clk       = 1'b0;
  logic        rx_rst_n     = 1'b0;
  logic        rx_clk_en_i  = 1'b1;
  logic        bypass_req_i = 1'b0;
  logic        forced_clr_i = 1'b0;
  logic        sel_bypass_o, frame_active_o, switch_done_o, forced_o;
  logic [15:0] switch_cnt_o;
  logic [1:0]  state_o;

  always #5 rx_clk = ~rx_clk;

  rx_bypass_ctrl_if xif ();

  rx_bypass_ctrl #(
    .TSE_LAT     (TSE_LAT),
    .SYNC_STAGES (SYNC_STAGES),
    .WAIT_W      (WAIT_W)
  ) dut (
    .rx_clk         (rx_clk),
    .rx_rst_n       (rx_rst_n),
    .rx_clk_en_i    (rx_clk_en_i),
    .bypass_req_i   (bypass_req_i),
    .forced_clr_i   (forced_clr_i),
    .xgmii          (xif),
    .sel_bypass_o   (sel_bypass_o),
    .frame_active_o (frame_active_o),
    .switch_done_o  (switch_done_o),
    .forced_o       (forced_o),
    .switch_cnt_o   (switch_cnt_o),
    .state_o        (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_drain:   a request differing from the current select is pending
  // m_idle:    consecutive enabled idle words seen while pending
  // m_wait:    enabled cycles spent pending
  bit          m_hist[SYNC_STAGES] = '{default: 1'b0};
  bit          m_sel    = 1'b0;
  bit          m_drain  = 1'b0;
  bit          m_frame  = 1'b0;
  bit          m_forced = 1'b0;
  bit          m_done   = 1'b0;
  int          m_idle   = 0;
  int          m_wait   = 0;
  logic [15:0] m_cnt    = '0;
  bit          r_req, r_start, r_term, r_idle, r_sw, r_frc;

  function automatic bit is_start(input logic [63:0] d, input logic [7:0] c);
    return (c[0] && d[7:0] == 8'hFB) || (c[4] && d[39:32] == 8'hFB);
  endfunction

  function automatic bit is_term(input logic [63:0] d, input logic [7:0] c);
    for (int k = 0; k < 8; k++) begin
      if (c[k] && d[8*k +: 8] == 8'hFD) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
      m_sel = 0; m_drain = 0; m_frame = 0; m_forced = 0; m_done = 0;
      m_idle = 0; m_wait = 0; m_cnt = '0;
    end else begin
      // Request as seen SYNC_STAGES edges late.
      r_req = m_hist[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = bypass_req_i;
      r_start = is_start(xif.xge_rxd_i, xif.xge_rxc_i);
      r_term  = is_term(xif.xge_rxd_i, xif.xge_rxc_i);
      r_idle  = rx_clk_en_i && !m_frame && !r_start;
      r_sw = 0; r_frc = 0;
      if (!m_drain) begin
        if (r_req != m_sel) begin m_drain = 1; m_idle = 0; m_wait = 0; end
      end else if (r_req == m_sel) begin
        m_drain = 0;
      end else if (rx_clk_en_i) begin
        if (m_wait == WAIT_MAX) begin r_sw = 1; r_frc = 1; end
        else if (r_idle && m_idle == TSE_LAT - 1) r_sw = 1;
        else begin
          m_wait = m_wait + 1;
          m_idle = r_idle ? m_idle + 1 : 0;
        end
      end
      if (r_sw) begin m_sel = !m_sel; m_drain = 0; m_cnt = m_cnt + 16'd1; end
      if (forced_clr_i) m_forced = 0;
      else if (r_frc) m_forced = 1;
      m_done = r_sw;
      if (rx_clk_en_i) m_frame = r_start ? 1'b1 : (r_term ? 1'b0 : m_frame);
      if (r_sw) exp_q.push_back({m_sel, m_forced, m_cnt});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [SB_W-1:0] sb_e;
  always @(negedge rx_clk) begin
    if (mon_en) begin
      check("sel_bypass", sel_bypass_o, m_sel);
      check("frame_active", frame_active_o, m_frame);
      check("switch_done", switch_done_o, m_done);
      check("forced", forced_o, m_forced);
      check("switch_cnt", switch_cnt_o, m_cnt);
      check("state", state_o, {m_sel, m_drain});
      check("rxts_trig", xif.rxts_trig_o, xif.rxts_trig_i & ~m_sel);
      if (switch_done_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: switch_done_o=1 with no switch predicted (t=%0t)", $time);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_switch", {sel_bypass_o, forced_o, switch_cnt_o}, sb_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put_word(input logic [63:0] d, input logic [7:0] c);
    xif.xge_rxd_i = d;
    xif.xge_rxc_i = c;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle_word();
    put_word(IDLE_D, 8'hFF);
  endtask

  task automatic data_word();
    put_word({$urandom, $urandom}, 8'h00);
  endtask

  task automatic start_word();
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[7:0] = 8'hFB;
    put_word(d, 8'h01);
  endtask

  task automatic start4_word();
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[31:0]  = {4{8'h07}};
    d[39:32] = 8'hFB;
    put_word(d, 8'h1F);
  endtask

  task automatic term_word(input int k);
    logic [63:0] d;
    logic [7:0]  c;
    d = {$urandom, $urandom};
    c = 8'hFF << k;
    for (int i = 0; i < 8; i++) if (i > k) d[8*i +: 8] = 8'h07;
    d[8*k +: 8] = 8'hFD;
    put_word(d, c);
  endtask

  // Terminate in lane k (<4) and a new start in lane 4 of the same word.
  task automatic term_start_word(input int k);
    logic [63:0] d;
    logic [7:0]  c;
    d = {$urandom, $urandom};
    c = 8'h10 | (8'h0F & (8'hFF << k));
    for (int i = 0; i < 4; i++) if (i > k) d[8*i +: 8] = 8'h07;
    d[8*k +: 8] = 8'hFD;
    d[39:32]    = 8'hFB;
    put_word(d, c);
  endtask

  task automatic send_frame(input int len);
    start_word();
    repeat (len - 2) data_word();
    term_word($urandom_range(0, 7));
  endtask

  task automatic random_word();
    case ($urandom_range(0, 9))
      0, 1, 2: idle_word();
      3, 4:    data_word();
      5:       start_word();
      6:       start4_word();
      7:       term_word($urandom_range(0, 7));
      8:       term_start_word($urandom_range(0, 3));
      default: put_word({8{8'hFE}}, 8'hFF);
    endcase
  endtask

  // ---------------- stimulus ----------------
  int lat;
  initial begin
    xif.xge_rxd_i   = IDLE_D;
    xif.xge_rxc_i   = 8'hFF;
    xif.rxts_trig_i = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    mon_en = 1'b1;
    check("reset_sel", sel_bypass_o, 1'b0);
    check("reset_cnt", switch_cnt_o, 16'd0);
    rx_rst_n = 1'b1;

    // 1: idle line, trigger passes through on the PTP path
    repeat (10) begin
      xif.rxts_trig_i = 1'($urandom_range(0, 1));
      idle_word();
    end

    // 2: request on an idle line; select moves after SYNC+1+TSE_LAT cycles
    bypass_req_i = 1'b1;
    lat = 0;
    while (sel_bypass_o !== 1'b1 && lat < 50) begin
      idle_word();
      lat++;
    end
    check("bypass_latency", lat, SYNC_STAGES + 1 + TSE_LAT);
    xif.rxts_trig_i = 1'b1;
    #1;
    check("trig_gated", xif.rxts_trig_o, 1'b0);
    repeat (4) idle_word();
    check("cnt_after_first", switch_cnt_o, 16'd1);

    // 3: withdraw during a 20-word frame; a new frame restarts the drain
    bypass_req_i = 1'b0;
    send_frame(20);
    repeat (2) idle_word();
    check("hold_mid_drain", sel_bypass_o, 1'b1);
    send_frame(5);
    repeat (3) idle_word();
    check("hold_after_restart", sel_bypass_o, 1'b1);
    repeat (5) idle_word();
    check("back_to_ptp", sel_bypass_o, 1'b0);

    // 4: short request pulse is withdrawn before the drain completes
    bypass_req_i = 1'b1;
    repeat (3) idle_word();
    bypass_req_i = 1'b0;
    repeat (10) idle_word();
    check("pulse_no_switch", sel_bypass_o, 1'b0);
    check("pulse_cnt", switch_cnt_o, 16'd2);

    // 5: continuous frame forces the switch; then clear coinciding with a force
    bypass_req_i = 1'b1;
    send_frame(100);
    check("forced_set", forced_o, 1'b1);
    check("forced_sel", sel_bypass_o, 1'b1);
    repeat (3) idle_word();
    bypass_req_i = 1'b0;
    start_word();
    repeat (100) begin
      forced_clr_i = (m_drain && m_wait == WAIT_MAX);
      data_word();
    end
    forced_clr_i = 1'b0;
    term_word(3);
    check("forced_clr_wins", forced_o, 1'b0);
    check("forced2_sel", sel_bypass_o, 1'b0);
    repeat (3) idle_word();

    // 6: clock enable toggling during the drain; term+start in one word
    bypass_req_i = 1'b1;
    lat = 0;
    while (sel_bypass_o !== 1'b1 && lat < 200) begin
      rx_clk_en_i = 1'($urandom_range(0, 1));
      idle_word();
      lat++;
    end
    rx_clk_en_i = 1'b1;
    check("en_toggle_switched", sel_bypass_o, 1'b1);
    start_word();
    data_word();
    term_start_word(2);
    check("term_start_active", frame_active_o, 1'b1);
    data_word();
    term_word(5);
    repeat (3) idle_word();

    // 7: reset in the middle of a drain and of a frame
    bypass_req_i = 1'b0;
    repeat (4) idle_word();
    start_word();
    rx_rst_n = 1'b0;
    #1;
    check("rst_mid_state", state_o, 2'b00);
    check("rst_mid_frame", frame_active_o, 1'b0);
    repeat (2) idle_word();
    rx_rst_n = 1'b1;
    repeat (4) idle_word();

    // 8: randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rx_clk_en_i     = ($urandom_range(0, 3) != 0);
      xif.rxts_trig_i = 1'($urandom_range(0, 1));
      forced_clr_i    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) bypass_req_i = ~bypass_req_i;
      if ($urandom_range(0, 999) == 0) rx_rst_n = 1'b0;
      else rx_rst_n = 1'b1;
      random_word();
    end
    rx_rst_n     = 1'b1;
    rx_clk_en_i  = 1'b1;
    forced_clr_i = 1'b0;
    repeat (10) idle_word();

    mon_en = 1'b0;
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
